// File: rtl/prog_counter_pkg.sv
// Shared constants for the program counter and the decoder that drives it:
// default word size and the op encodings.
package prog_counter_pkg;

    localparam int WORD_SIZE_DEF = 16;

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_STEP = 3'd1;
    localparam logic [2:0] OP_JUMP = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;

endpackage

// File: rtl/prog_counter_return_stack.sv
// Circular LIFO of return addresses. A push when full overwrites the oldest
// entry. A pop when empty is ignored.
module prog_counter_return_stack
    import prog_counter_pkg::*;
#(
    parameter int WORD_SIZE   = WORD_SIZE_DEF,
    parameter int STACK_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WORD_SIZE-1:0]           din,
    output logic [WORD_SIZE-1:0]           top,
    output logic [$clog2(STACK_DEPTH):0]   depth,
    output logic                           full,
    output logic                           empty
);

    localparam int PW = $clog2(STACK_DEPTH);

    logic [WORD_SIZE-1:0] mem_r [STACK_DEPTH];
    logic [PW-1:0]        sp_r;
    logic [PW:0]          count_r;
    logic [PW-1:0]        top_idx_s;

    assign top_idx_s = sp_r - PW'(1);
    assign top       = mem_r[top_idx_s];
    assign depth     = count_r;
    assign full      = (count_r == (PW+1)'(STACK_DEPTH));
    assign empty     = (count_r == '0);

    // Entry storage; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_r[sp_r] <= din;
        end
    end

    // Stack pointer wraps modulo the depth; the count saturates at full.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_r    <= '0;
            count_r <= '0;
        end else if (push) begin
            sp_r <= sp_r + PW'(1);
            if (!full) begin
                count_r <= count_r + (PW+1)'(1);
            end
        end else if (pop && !empty) begin
            sp_r    <= sp_r - PW'(1);
            count_r <= count_r - (PW+1)'(1);
        end
    end

endmodule

// File: rtl/prog_counter.sv
// Program counter with relative step, absolute jump and a hardware
// call/return stack; overflow/underflow are sticky until reset.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int WORD_SIZE    = WORD_SIZE_DEF,
    parameter int STACK_DEPTH  = 4,
    parameter int RESET_VECTOR = 0,
    parameter int RET_OFFSET   = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic [2:0]                     op,
    input  logic [WORD_SIZE-1:0]           adj,
    input  logic [WORD_SIZE-1:0]           target,
    output logic [WORD_SIZE-1:0]           pc,
    output logic [$clog2(STACK_DEPTH):0]   depth,
    output logic                           overflow,
    output logic                           underflow
);

    logic [WORD_SIZE-1:0] pc_r;
    logic [WORD_SIZE-1:0] pc_next_s;
    logic [WORD_SIZE-1:0] ret_addr_s;
    logic [WORD_SIZE-1:0] stack_top_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 full_s;
    logic                 empty_s;
    logic                 ovf_set_s;
    logic                 unf_set_s;
    logic                 overflow_r;
    logic                 underflow_r;

    assign ret_addr_s = pc_r + WORD_SIZE'(RET_OFFSET);
    assign pc         = pc_r;
    assign overflow   = overflow_r;
    assign underflow  = underflow_r;

    // Next-pc mux and stack control; a stall suppresses everything.
    always_comb begin
        pc_next_s = pc_r;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        ovf_set_s = 1'b0;
        unf_set_s = 1'b0;
        if (!stall) begin
            case (op)
                OP_STEP: pc_next_s = pc_r + adj;
                OP_JUMP: pc_next_s = target;
                OP_CALL: begin
                    pc_next_s = target;
                    push_s    = 1'b1;
                    ovf_set_s = full_s;
                end
                OP_RET: begin
                    if (empty_s) begin
                        unf_set_s = 1'b1;
                    end else begin
                        pc_next_s = stack_top_s;
                        pop_s     = 1'b1;
                    end
                end
                default: pc_next_s = pc_r;
            endcase
        end else begin
            pc_next_s = pc_r;
        end
    end

    // PC register and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r        <= WORD_SIZE'(RESET_VECTOR);
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            pc_r        <= pc_next_s;
            overflow_r  <= overflow_r | ovf_set_s;
            underflow_r <= underflow_r | unf_set_s;
        end
    end

    prog_counter_return_stack #(
        .WORD_SIZE   (WORD_SIZE),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (ret_addr_s),
        .top   (stack_top_s),
        .depth (depth),
        .full  (full_s),
        .empty (empty_s)
    );

endmodule

// File: tb/tb_prog_counter.sv
// Directed-vector bench for prog_counter (16-bit, depth 4, reset vector 0,
// return offset 1) with hand-computed expected values.
module tb_prog_counter;
    import prog_counter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  op;
    logic [15:0] adj;
    logic [15:0] target;
    logic [15:0] pc;
    logic [2:0]  depth;
    logic        overflow;
    logic        underflow;

    int n_vec = 0;
    int n_err = 0;

    prog_counter #(
        .WORD_SIZE    (16),
        .STACK_DEPTH  (4),
        .RESET_VECTOR (0),
        .RET_OFFSET   (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .op        (op),
        .adj       (adj),
        .target    (target),
        .pc        (pc),
        .depth     (depth),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then settle past the edge.
    task automatic apply(input logic rst, input logic stl, input logic [2:0] o,
                         input logic [15:0] a, input logic [15:0] t);
        @(negedge clk);
        reset  = rst;
        stall  = stl;
        op     = o;
        adj    = a;
        target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b0, OP_HOLD, 16'h0000, 16'h0000);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; op = OP_HOLD; adj = 16'h0000; target = 16'h0000;

        // 1. reset state and stepping
        do_reset();
        check_val("rst_pc", pc, 32'h0);
        check_val("rst_depth", depth, 32'h0);
        check_val("rst_ovf", overflow, 32'h0);
        check_val("rst_unf", underflow, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            apply(1'b0, 1'b0, OP_STEP, 16'h0001, 16'h0000);
            check_val("step1", pc, 32'(i));
        end
        apply(1'b0, 1'b0, OP_STEP, 16'hFFFE, 16'h0000);
        check_val("step_neg", pc, 32'h1);
        apply(1'b0, 1'b0, 3'd6, 16'h0005, 16'h1234);
        check_val("op6_hold", pc, 32'h1);

        // 2. wrap and jump
        apply(1'b0, 1'b0, OP_JUMP, 16'h0000, 16'hFFFF);
        check_val("jump_ffff", pc, 32'hFFFF);
        apply(1'b0, 1'b0, OP_STEP, 16'h0002, 16'h0000);
        check_val("wrap_pc", pc, 32'h1);
        check_val("wrap_ovf", overflow, 32'h0);
        check_val("wrap_unf", underflow, 32'h0);
        apply(1'b0, 1'b0, OP_JUMP, 16'h0000, 16'h0100);
        check_val("jump_100", pc, 32'h100);

        // 3. nested call/return
        apply(1'b0, 1'b0, OP_JUMP, 16'h0000, 16'h0010);
        apply(1'b0, 1'b0, OP_CALL, 16'h0000, 16'h0200);
        check_val("call1_pc", pc, 32'h200);
        check_val("call1_depth", depth, 32'h1);
        apply(1'b0, 1'b0, OP_CALL, 16'h0000, 16'h0300);
        check_val("call2_pc", pc, 32'h300);
        check_val("call2_depth", depth, 32'h2);
        apply(1'b0, 1'b0, OP_RET, 16'h0000, 16'h0000);
        check_val("ret1_pc", pc, 32'h201);
        check_val("ret1_depth", depth, 32'h1);
        apply(1'b0, 1'b0, OP_RET, 16'h0000, 16'h0000);
        check_val("ret2_pc", pc, 32'h11);
        check_val("ret2_depth", depth, 32'h0);

        // 4. overflow: fifth call overwrites the oldest entry
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            apply(1'b0, 1'b0, OP_CALL, 16'h0000, 16'(i * 16));
            check_val("ovf_call_pc", pc, 32'(i * 16));
            check_val("ovf_call_depth", depth, (i > 4) ? 32'd4 : 32'(i));
            check_val("ovf_flag", overflow, (i == 5) ? 32'h1 : 32'h0);
        end
        for (int i = 4; i >= 1; i--) begin
            apply(1'b0, 1'b0, OP_RET, 16'h0000, 16'h0000);
            check_val("ovf_ret_pc", pc, 32'(i * 16 + 1));
            check_val("ovf_ret_depth", depth, 32'(i - 1));
        end

        // 5. underflow, sticky flags, reset clears them
        apply(1'b0, 1'b0, OP_RET, 16'h0000, 16'h0000);
        check_val("unf_pc", pc, 32'h11);
        check_val("unf_depth", depth, 32'h0);
        check_val("unf_flag", underflow, 32'h1);
        check_val("ovf_sticky", overflow, 32'h1);
        apply(1'b0, 1'b0, OP_STEP, 16'h0001, 16'h0000);
        check_val("unf_sticky", underflow, 32'h1);
        do_reset();
        check_val("rst2_pc", pc, 32'h0);
        check_val("rst2_ovf", overflow, 32'h0);
        check_val("rst2_unf", underflow, 32'h0);

        // 6. stall and reset priority
        apply(1'b0, 1'b0, OP_JUMP, 16'h0000, 16'h0077);
        apply(1'b0, 1'b1, OP_CALL, 16'h0000, 16'h0099);
        check_val("stall_call_pc", pc, 32'h77);
        check_val("stall_call_depth", depth, 32'h0);
        apply(1'b0, 1'b0, OP_CALL, 16'h0000, 16'h0077);
        check_val("self_call_pc", pc, 32'h77);
        check_val("self_call_depth", depth, 32'h1);
        apply(1'b0, 1'b1, OP_RET, 16'h0000, 16'h0000);
        check_val("stall_ret_pc", pc, 32'h77);
        check_val("stall_ret_depth", depth, 32'h1);
        apply(1'b0, 1'b1, OP_RET, 16'h0000, 16'h0000);
        apply(1'b0, 1'b0, OP_RET, 16'h0000, 16'h0000);
        check_val("self_ret_pc", pc, 32'h78);
        apply(1'b1, 1'b0, OP_JUMP, 16'h0000, 16'h0055);
        check_val("rst_jump_pc", pc, 32'h0);
        check_val("rst_jump_depth", depth, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
